// File: rtl/csr_unit_if.sv
// csr_unit_if: EX-stage CSR access bundle between the pipeline and csr_unit.
//   master modport : pipeline side. It drives the instruction fields and retire,
//                    and receives the old CSR value and the illegal flag.
//   slave modport  : csr_unit side.
// Signals:
//   csr_valid   EX holds a CSR instruction this cycle
//   stall       pipeline stall; suppresses the CSR write
//   alu_ctrl    5-bit op from the ALU-control decoder (5'h12..5'h17 are CSR ops)
//   csr_addr    12-bit CSR address
//   rs1_idx     rs1 field, doubles as zimm for the immediate variants
//   rs1_data    forwarded rs1 value
//   retire      one instruction retired this cycle
//   csr_rdata   old CSR value (combinational)
//   csr_illegal illegal access (combinational)
interface csr_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            csr_valid;
  logic            stall;
  logic [4:0]      alu_ctrl;
  logic [11:0]     csr_addr;
  logic [4:0]      rs1_idx;
  logic [XLEN-1:0] rs1_data;
  logic            retire;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  modport master (
    output csr_valid, stall, alu_ctrl, csr_addr, rs1_idx, rs1_data, retire,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_valid, stall, alu_ctrl, csr_addr, rs1_idx, rs1_data, retire,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_unit.sv
// csr_unit: EX-stage CSR file. Executes CSRRW/S/C and CSRRWI/SI/CI, holds the
// 64-bit cycle and instret counters plus mscratch. It returns the pre-write CSR
// value for rd writeback and flags illegal accesses.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   csr_unit_if slave modport (instruction fields in, rdata/illegal out)
module csr_unit #(
  parameter int unsigned        XLEN      = 32,
  parameter logic [2*XLEN-1:0]  CYCLE_RST = '0
) (
  input  logic       clk,
  input  logic       rst_n,
  csr_unit_if.slave  bus
);

  localparam logic [4:0] OP_RW  = 5'h12;
  localparam logic [4:0] OP_RS  = 5'h13;
  localparam logic [4:0] OP_RC  = 5'h14;
  localparam logic [4:0] OP_RWI = 5'h15;
  localparam logic [4:0] OP_RSI = 5'h16;
  localparam logic [4:0] OP_RCI = 5'h17;

  localparam logic [2*XLEN-1:0] CNT_ONE = {{(2*XLEN-1){1'b0}}, 1'b1};

  logic [2*XLEN-1:0] cycle_q, cycle_d;
  logic [2*XLEN-1:0] instret_q, instret_d;
  logic [XLEN-1:0]   mscratch_q, mscratch_d;

  logic            is_csr_op;
  logic            imm_op;
  logic            rw_op;
  logic            set_op;
  logic            op_writes;
  logic            hit;
  logic            read_only;
  logic            illegal;
  logic            we;
  logic [XLEN-1:0] opnd;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic            sel_cyc_lo, sel_cyc_hi, sel_ins_lo, sel_ins_hi, sel_scr;

  // Decode, read mux and write-value computation.
  always_comb begin
    is_csr_op  = bus.csr_valid && (bus.alu_ctrl >= OP_RW) && (bus.alu_ctrl <= OP_RCI);
    imm_op     = (bus.alu_ctrl == OP_RWI) || (bus.alu_ctrl == OP_RSI) ||
                 (bus.alu_ctrl == OP_RCI);
    rw_op      = (bus.alu_ctrl == OP_RW) || (bus.alu_ctrl == OP_RWI);
    set_op     = (bus.alu_ctrl == OP_RS) || (bus.alu_ctrl == OP_RSI);
    opnd       = imm_op ? {{(XLEN-5){1'b0}}, bus.rs1_idx} : bus.rs1_data;
    // Set/clear with rs1 = x0 (or zimm = 0) is a pure read; swaps always write.
    op_writes  = rw_op || (bus.rs1_idx != 5'd0);

    hit        = 1'b1;
    old_val    = '0;
    sel_cyc_lo = 1'b0;
    sel_cyc_hi = 1'b0;
    sel_ins_lo = 1'b0;
    sel_ins_hi = 1'b0;
    sel_scr    = 1'b0;
    // The user-level counters (Cxx) and the machine aliases (Bxx) share storage.
    unique case (bus.csr_addr)
      12'hC00, 12'hB00: begin sel_cyc_lo = 1'b1; old_val = cycle_q[XLEN-1:0];        end
      12'hC80, 12'hB80: begin sel_cyc_hi = 1'b1; old_val = cycle_q[2*XLEN-1:XLEN];   end
      12'hC02, 12'hB02: begin sel_ins_lo = 1'b1; old_val = instret_q[XLEN-1:0];      end
      12'hC82, 12'hB82: begin sel_ins_hi = 1'b1; old_val = instret_q[2*XLEN-1:XLEN]; end
      12'h340:          begin sel_scr    = 1'b1; old_val = mscratch_q;               end
      default:          hit = 1'b0;
    endcase

    // Address bits [11:10] == 2'b11 mark the read-only space.
    read_only = (bus.csr_addr[11:10] == 2'b11);
    illegal   = is_csr_op && (!hit || (read_only && op_writes));

    if (rw_op) begin
      new_val = opnd;
    end else if (set_op) begin
      new_val = old_val | opnd;
    end else begin
      new_val = old_val & ~opnd;
    end

    we = is_csr_op && !bus.stall && !illegal && op_writes;
  end

  assign bus.csr_rdata   = (is_csr_op && hit) ? old_val : '0;
  assign bus.csr_illegal = illegal;

  // Next-state for the counters and mscratch. A software write to one half
  // replaces that half, holds the other, and suppresses the increment.
  always_comb begin
    cycle_d    = cycle_q + CNT_ONE;
    instret_d  = bus.retire ? (instret_q + CNT_ONE) : instret_q;
    mscratch_d = mscratch_q;

    if (we) begin
      if (sel_cyc_lo) cycle_d   = {cycle_q[2*XLEN-1:XLEN], new_val};
      if (sel_cyc_hi) cycle_d   = {new_val, cycle_q[XLEN-1:0]};
      if (sel_ins_lo) instret_d = {instret_q[2*XLEN-1:XLEN], new_val};
      if (sel_ins_hi) instret_d = {new_val, instret_q[XLEN-1:0]};
      if (sel_scr)    mscratch_d = new_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q    <= CYCLE_RST;
      instret_q  <= '0;
      mscratch_q <= '0;
    end else begin
      cycle_q    <= cycle_d;
      instret_q  <= instret_d;
      mscratch_q <= mscratch_d;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
module tb_csr_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  csr_unit_if #(.XLEN(32)) bus ();

  csr_unit #(.XLEN(32), .CYCLE_RST(64'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        st;
    logic [4:0]  ctrl;
    logic [11:0] addr;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_ill;
    string       name;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs[NVEC];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end else begin
      $display("ok   %s value=%h", nm, got);
    end
  endtask

  // Drive one instruction half a cycle before the next rising edge and let the
  // combinational outputs settle.
  task automatic apply(input logic v, input logic st, input logic ret,
                       input logic [4:0] ctrl, input logic [11:0] addr,
                       input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    bus.csr_valid = v;
    bus.stall     = st;
    bus.retire    = ret;
    bus.alu_ctrl  = ctrl;
    bus.csr_addr  = addr;
    bus.rs1_idx   = idx;
    bus.rs1_data  = data;
    #1;
  endtask

  // Plain read: CSRRS with rs1 = x0.
  task automatic rd(input logic [11:0] addr);
    apply(1'b1, 1'b0, 1'b0, 5'h13, addr, 5'd0, 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n          = 1'b0;
    bus.csr_valid  = 1'b0;
    bus.stall      = 1'b0;
    bus.retire     = 1'b0;
    bus.alu_ctrl   = 5'h0;
    bus.csr_addr   = 12'h0;
    bus.rs1_idx    = 5'd0;
    bus.rs1_data   = 32'h0;

    //             v     st    ctrl   addr     idx    data          chk   exp_rd        ill
    vecs[0]  = '{1'b1, 1'b0, 5'h12, 12'h340, 5'd1,  32'hDEADBEEF, 1'b1, 32'h00000000, 1'b0, "rw_scr"};
    vecs[1]  = '{1'b1, 1'b0, 5'h13, 12'h340, 5'd0,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0, "rd_scr_a"};
    vecs[2]  = '{1'b1, 1'b0, 5'h17, 12'h340, 5'h0F, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, "rci_scr"};
    vecs[3]  = '{1'b1, 1'b0, 5'h13, 12'h340, 5'd0,  32'h0,        1'b1, 32'hDEADBEE0, 1'b0, "rd_scr_b"};
    vecs[4]  = '{1'b1, 1'b0, 5'h16, 12'h340, 5'd0,  32'hFFFFFFFF, 1'b1, 32'hDEADBEE0, 1'b0, "rsi_zero"};
    vecs[5]  = '{1'b1, 1'b0, 5'h13, 12'h340, 5'd0,  32'h0,        1'b1, 32'hDEADBEE0, 1'b0, "rd_scr_c"};
    vecs[6]  = '{1'b1, 1'b0, 5'h13, 12'h340, 5'd1,  32'h00000010, 1'b1, 32'hDEADBEE0, 1'b0, "rs_scr"};
    vecs[7]  = '{1'b1, 1'b0, 5'h14, 12'h340, 5'd2,  32'hFFFF0000, 1'b1, 32'hDEADBEF0, 1'b0, "rc_scr"};
    vecs[8]  = '{1'b1, 1'b1, 5'h12, 12'h340, 5'd1,  32'h00001234, 1'b1, 32'h0000BEF0, 1'b0, "rw_stall"};
    vecs[9]  = '{1'b1, 1'b0, 5'h13, 12'h340, 5'd0,  32'h0,        1'b1, 32'h0000BEF0, 1'b0, "rd_after_stall"};
    vecs[10] = '{1'b1, 1'b0, 5'h12, 12'hC02, 5'd1,  32'h00000005, 1'b0, 32'h0,        1'b1, "rw_ro_instret"};
    vecs[11] = '{1'b1, 1'b0, 5'h13, 12'hC02, 5'd0,  32'h0,        1'b1, 32'h00000000, 1'b0, "rd_instret"};
    vecs[12] = '{1'b1, 1'b0, 5'h12, 12'h7C0, 5'd1,  32'h00000001, 1'b1, 32'h00000000, 1'b1, "rw_unmapped"};
    vecs[13] = '{1'b1, 1'b0, 5'h16, 12'hC00, 5'd3,  32'h0,        1'b0, 32'h0,        1'b1, "rsi_ro_cycle"};
    vecs[14] = '{1'b1, 1'b0, 5'h05, 12'h340, 5'd1,  32'h00000099, 1'b1, 32'h00000000, 1'b0, "non_csr_op"};
    vecs[15] = '{1'b1, 1'b0, 5'h13, 12'h340, 5'd0,  32'h0,        1'b1, 32'h0000BEF0, 1'b0, "rd_after_noncsr"};
    vecs[16] = '{1'b0, 1'b0, 5'h12, 12'h340, 5'd1,  32'h00001234, 1'b1, 32'h00000000, 1'b0, "not_valid"};
    vecs[17] = '{1'b1, 1'b0, 5'h13, 12'h340, 5'd0,  32'h0,        1'b1, 32'h0000BEF0, 1'b0, "rd_after_invalid"};
    vecs[18] = '{1'b1, 1'b0, 5'h15, 12'h340, 5'd0,  32'h0,        1'b1, 32'h0000BEF0, 1'b0, "rwi_zero"};
    vecs[19] = '{1'b1, 1'b0, 5'h13, 12'h340, 5'd0,  32'h0,        1'b1, 32'h00000000, 1'b0, "rd_after_rwi"};
    vecs[20] = '{1'b1, 1'b0, 5'h18, 12'h340, 5'd1,  32'h00000005, 1'b1, 32'h00000000, 1'b0, "op_out_of_range"};
    vecs[21] = '{1'b1, 1'b0, 5'h13, 12'h340, 5'd0,  32'h0,        1'b1, 32'h00000000, 1'b0, "rd_after_oor"};
    vecs[22] = '{1'b1, 1'b0, 5'h16, 12'h340, 5'd5,  32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, "rsi_scr"};
    vecs[23] = '{1'b1, 1'b0, 5'h13, 12'h340, 5'd0,  32'h0,        1'b1, 32'h00000005, 1'b0, "rd_after_rsi"};
    vecs[24] = '{1'b1, 1'b0, 5'h13, 12'hC80, 5'd0,  32'h0,        1'b1, 32'h00000000, 1'b0, "rd_cycle_hi"};
    vecs[25] = '{1'b1, 1'b0, 5'h12, 12'hC82, 5'd1,  32'h00000007, 1'b0, 32'h0,        1'b1, "rw_ro_instret_hi"};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_rdata_idle", bus.csr_rdata, 32'h0);
    chk("reset_illegal_idle", {31'b0, bus.csr_illegal}, 32'h0);
    bus.csr_valid = 1'b1;
    bus.alu_ctrl  = 5'h13;
    bus.csr_addr  = 12'hC00;
    #1;
    chk("reset_cycle", bus.csr_rdata, 32'h0);

    // Release reset, let 10 edges pass, read the count.
    @(negedge clk);
    rst_n         = 1'b1;
    bus.csr_valid = 1'b0;
    repeat (10) @(posedge clk);
    rd(12'hC00);
    chk("cycle_after_10", bus.csr_rdata, 32'd10);
    chk("cycle_read_legal", {31'b0, bus.csr_illegal}, 32'h0);
    apply(1'b1, 1'b1, 1'b0, 5'h13, 12'hC00, 5'd0, 32'h0);
    chk("cycle_stall_read", bus.csr_rdata, 32'd11);
    rd(12'hC00);
    chk("cycle_counts_in_stall", bus.csr_rdata, 32'd12);

    // Table-driven vectors, one instruction per cycle.
    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].v, vecs[i].st, 1'b0, vecs[i].ctrl, vecs[i].addr, vecs[i].idx, vecs[i].data);
      if (vecs[i].chk_rd) chk({vecs[i].name, ".rdata"}, bus.csr_rdata, vecs[i].exp_rd);
      chk({vecs[i].name, ".illegal"}, {31'b0, bus.csr_illegal}, {31'b0, vecs[i].exp_ill});
    end

    // instret: three retires, then write-wins over a simultaneous retire.
    repeat (3) apply(1'b0, 1'b0, 1'b1, 5'h0, 12'h0, 5'd0, 32'h0);
    rd(12'hC02);
    chk("instret_3", bus.csr_rdata, 32'd3);
    apply(1'b1, 1'b0, 1'b1, 5'h12, 12'hB02, 5'd1, 32'd100);
    chk("minstret_lo_old", bus.csr_rdata, 32'd3);
    apply(1'b1, 1'b0, 1'b1, 5'h12, 12'hB82, 5'd1, 32'd7);
    chk("minstret_hi_old", bus.csr_rdata, 32'd0);
    rd(12'hC02);
    chk("instret_lo_write_wins", bus.csr_rdata, 32'd100);
    rd(12'hC82);
    chk("instret_hi_written", bus.csr_rdata, 32'd7);

    // Carry lo->hi.
    apply(1'b1, 1'b0, 1'b0, 5'h12, 12'hB80, 5'd1, 32'h0);
    apply(1'b1, 1'b0, 1'b0, 5'h12, 12'hB00, 5'd1, 32'hFFFFFFFF);
    rd(12'hC00);
    chk("cycle_lo_written", bus.csr_rdata, 32'hFFFFFFFF);
    rd(12'hC80);
    chk("cycle_carry_hi", bus.csr_rdata, 32'd1);
    rd(12'hC00);
    chk("cycle_lo_after_carry", bus.csr_rdata, 32'd1);

    // Full 64-bit wrap.
    apply(1'b1, 1'b0, 1'b0, 5'h12, 12'hB00, 5'd1, 32'hFFFFFFFF);
    apply(1'b1, 1'b0, 1'b0, 5'h12, 12'hB80, 5'd1, 32'hFFFFFFFF);
    chk("mcycle_hi_old", bus.csr_rdata, 32'd1);
    rd(12'hC00);
    chk("cycle_all_ones_lo", bus.csr_rdata, 32'hFFFFFFFF);
    rd(12'hC80);
    chk("cycle_wrap_hi", bus.csr_rdata, 32'd0);
    rd(12'hC00);
    chk("cycle_wrap_lo", bus.csr_rdata, 32'd1);

    // Reset mid-operation discards the pending write.
    apply(1'b1, 1'b0, 1'b0, 5'h12, 12'h340, 5'd1, 32'h55);
    apply(1'b1, 1'b0, 1'b0, 5'h12, 12'h340, 5'd1, 32'h77);
    chk("scr_before_reset", bus.csr_rdata, 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    chk("scr_async_reset", bus.csr_rdata, 32'h0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.alu_ctrl  = 5'h13;
    bus.csr_addr  = 12'hC00;
    bus.rs1_idx   = 5'd0;
    #1;
    chk("cycle_after_mid_reset", bus.csr_rdata, 32'h0);
    rd(12'hC02);
    chk("instret_after_mid_reset", bus.csr_rdata, 32'h0);
    rd(12'hC82);
    chk("instret_hi_after_mid_reset", bus.csr_rdata, 32'h0);
    rd(12'h340);
    chk("scr_after_mid_reset", bus.csr_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
